// File: rtl/rect_fill_pkg.sv
// rect_fill_pkg: shared types and constants for the rectangle filler.
//   fill_mode_e      : colour mode selector (SOLID, COLS, ROWS, CHECKER)
//   state_e          : controller states (IDLE, SETUP, FILL, DONE)
//   DEFAULT_SCREEN_W : default screen width in pixels
//   DEFAULT_SCREEN_H : default screen height in pixels
package rect_fill_pkg;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        COLS    = 2'd1,
        ROWS    = 2'd2,
        CHECKER = 2'd3
    } fill_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEFAULT_SCREEN_W = 160;
    localparam int DEFAULT_SCREEN_H = 120;

endpackage

// File: rtl/rect_fill_if.sv
// rect_fill_if: request/handshake and plot bus between the drawing
// controller (master) and the rectangle filler (slave).
//   start, x0, x1, y0, y1, mode, colour : request from the controller
//   busy, done                          : status back to the controller
//   vga_x, vga_y, vga_colour, vga_plot  : pixel stream to the VGA adapter
interface rect_fill_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    import rect_fill_pkg::*;

    logic                start;
    logic [X_W-1:0]      x0;
    logic [X_W-1:0]      x1;
    logic [Y_W-1:0]      y0;
    logic [Y_W-1:0]      y1;
    fill_mode_e          mode;
    logic [COLOUR_W-1:0] colour;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output start, x0, x1, y0, y1, mode, colour,
        input  busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, x0, x1, y0, y1, mode, colour,
        output busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/rect_fill_scan_counter_2d.sv
// scan_counter_2d: column-major raster counter over [xl..xh] x [yl..yh].
//   clk, rst_n : clock, synchronous active-low reset
//   load       : jump to (xl, yl)
//   step       : advance one pixel (y fastest, wraps to yl and bumps x)
//   xl,xh,yl,yh: inclusive bounds, must be stable while stepping
//   x, y       : current position
//   last       : current position is (xh, yh)
module scan_counter_2d #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] xl,
    input  logic [X_W-1:0] xh,
    input  logic [Y_W-1:0] yl,
    input  logic [Y_W-1:0] yh,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    assign last = (x == xh) && (y == yh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= xl;
            y <= yl;
        end else if (step && !last) begin
            // Column wrap costs no extra cycle: reload y and bump x together.
            if (y == yh) begin
                y <= yl;
                x <= x + X_W'(1);
            end else begin
                y <= y + Y_W'(1);
            end
        end
    end

endmodule

// File: rtl/rect_fill.sv
// rect_fill: raster-scans an axis-aligned rectangle and emits one plot
// request per cycle towards the VGA adapter.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : rect_fill_if.slave
//                request  start (level, held until done), x0/x1, y0/y1
//                         (corners, any order), mode, colour
//                status   busy (SETUP/FILL), done (fill complete)
//                pixels   vga_x, vga_y, vga_colour, vga_plot (registered)
// Optional feature macro: RECT_FILL_CLIP_EN -- clamps corners to the
// screen during SETUP so no off-screen pixel is ever plotted.
module rect_fill
    import rect_fill_pkg::*;
#(
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    rect_fill_if.slave bus
);

    state_e              state;
    logic [X_W-1:0]      rx0, rx1;
    logic [Y_W-1:0]      ry0, ry1;
    fill_mode_e          rmode;
    logic [COLOUR_W-1:0] rcolour;
    // Set when the pixel currently on the outputs is the final one.
    logic                vga_last;

    logic [X_W-1:0]      ax0, ax1, xl, xh;
    logic [Y_W-1:0]      ay0, ay1, yl, yh;
    logic [X_W-1:0]      cnt_x;
    logic [Y_W-1:0]      cnt_y;
    logic                cnt_last;
    logic [COLOUR_W-1:0] nxt_colour;

    // Bounds are derived from the captured request, which is frozen
    // outside IDLE, so they stay valid for the whole scan.
    always_comb begin
        ax0 = rx0;
        ax1 = rx1;
        ay0 = ry0;
        ay1 = ry1;
`ifdef RECT_FILL_CLIP_EN
        if (int'(rx0) >= SCREEN_W) ax0 = X_W'(SCREEN_W - 1);
        if (int'(rx1) >= SCREEN_W) ax1 = X_W'(SCREEN_W - 1);
        if (int'(ry0) >= SCREEN_H) ay0 = Y_W'(SCREEN_H - 1);
        if (int'(ry1) >= SCREEN_H) ay1 = Y_W'(SCREEN_H - 1);
`endif
        xl = (ax0 < ax1) ? ax0 : ax1;
        xh = (ax0 < ax1) ? ax1 : ax0;
        yl = (ay0 < ay1) ? ay0 : ay1;
        yh = (ay0 < ay1) ? ay1 : ay0;
    end

    scan_counter_2d #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == SETUP),
        .step  (state == FILL && !vga_last),
        .xl    (xl),
        .xh    (xh),
        .yl    (yl),
        .yh    (yh),
        .x     (cnt_x),
        .y     (cnt_y),
        .last  (cnt_last)
    );

    // Colour follows the counter position that is about to be registered,
    // so vga_colour lines up with vga_x/vga_y.
    always_comb begin
        nxt_colour = rcolour;
        case (rmode)
            SOLID:   nxt_colour = rcolour;
            COLS:    nxt_colour = COLOUR_W'(cnt_x);
            ROWS:    nxt_colour = COLOUR_W'(cnt_y);
            CHECKER: nxt_colour = (cnt_x[3] ^ cnt_y[3]) ? '0 : rcolour;
            default: nxt_colour = rcolour;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            rx0            <= '0;
            rx1            <= '0;
            ry0            <= '0;
            ry1            <= '0;
            rmode          <= SOLID;
            rcolour        <= '0;
            vga_last       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rx0      <= bus.x0;
                        rx1      <= bus.x1;
                        ry0      <= bus.y0;
                        ry1      <= bus.y1;
                        rmode    <= bus.mode;
                        rcolour  <= bus.colour;
                        bus.busy <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    bus.vga_x <= xl;
                    bus.vga_y <= yl;
                    vga_last  <= 1'b0;
                    state     <= FILL;
                end
                FILL: begin
                    if (vga_last) begin
                        // Final pixel has been presented; coordinates hold.
                        bus.vga_plot <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        vga_last     <= 1'b0;
                        state        <= DONE;
                    end else begin
                        bus.vga_x      <= cnt_x;
                        bus.vga_y      <= cnt_y;
                        bus.vga_colour <= nxt_colour;
                        bus.vga_plot   <= 1'b1;
                        vga_last       <= cnt_last;
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        bus.done <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: self-checking bench for rect_fill. A reference model
// enumerates the expected pixel list per rectangle from the corner/colour
// rules and is compared against the observed plot stream and handshake.
// Honours RECT_FILL_CLIP_EN the same way as the design.
module tb_rect_fill;
    import rect_fill_pkg::*;

    localparam int SW = 160;
    localparam int SH = 120;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rect_fill_if #(.X_W(XW), .Y_W(YW), .COLOUR_W(CW)) bus ();

    rect_fill #(
        .SCREEN_W (SW),
        .SCREEN_H (SH),
        .X_W      (XW),
        .Y_W      (YW),
        .COLOUR_W (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int exp_colour(input int md, input int col, input int x, input int y);
        case (md)
            0: return col;
            1: return x % 8;
            2: return y % 8;
            default: return ((((x / 8) % 2) ^ ((y / 8) % 2)) == 0) ? col : 0;
        endcase
    endfunction

    // Runs one fill from a raised start until done is observed; start is
    // left high on return so the caller controls the release.
    task automatic do_fill(input string nm, input int ax0, input int ax1,
                           input int ay0, input int ay1, input int md, input int col);
        int ex[$];
        int ey[$];
        int ec[$];
        int xl, xh, yl, yh, n, rel, cnt, first_rel, done_rel, errs;
`ifdef RECT_FILL_CLIP_EN
        if (ax0 > SW - 1) ax0 = SW - 1;
        if (ax1 > SW - 1) ax1 = SW - 1;
        if (ay0 > SH - 1) ay0 = SH - 1;
        if (ay1 > SH - 1) ay1 = SH - 1;
`endif
        xl = (ax0 < ax1) ? ax0 : ax1;
        xh = (ax0 < ax1) ? ax1 : ax0;
        yl = (ay0 < ay1) ? ay0 : ay1;
        yh = (ay0 < ay1) ? ay1 : ay0;
        for (int x = xl; x <= xh; x++)
            for (int y = yl; y <= yh; y++) begin
                ex.push_back(x);
                ey.push_back(y);
                ec.push_back(exp_colour(md, col, x, y));
            end
        n = ex.size();

        @(negedge clk);
        bus.x0     = XW'(ax0);
        bus.x1     = XW'(ax1);
        bus.y0     = YW'(ay0);
        bus.y1     = YW'(ay1);
        bus.mode   = fill_mode_e'(md[1:0]);
        bus.colour = CW'(col);
        bus.start  = 1'b1;
        @(posedge clk);   // request sampled here
        rel = 0; cnt = 0; first_rel = -1; done_rel = -1; errs = 0;
        while (done_rel < 0 && rel < n + 20) begin
            @(posedge clk);
            #1;
            rel++;
            if (bus.vga_plot === 1'b1) begin
                if (cnt >= n) begin
                    errs++;
                end else if (bus.vga_x !== XW'(ex[cnt]) || bus.vga_y !== YW'(ey[cnt]) ||
                             bus.vga_colour !== CW'(ec[cnt]) || rel != cnt + 2 ||
                             bus.busy !== 1'b1) begin
                    if (errs == 0)
                        $display("%s: first bad pixel #%0d at cycle %0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                 nm, cnt, rel, bus.vga_x, bus.vga_y, bus.vga_colour,
                                 ex[cnt], ey[cnt], ec[cnt]);
                    errs++;
                end
                if (first_rel < 0) first_rel = rel;
                cnt++;
            end
            if (bus.done === 1'b1) done_rel = rel;
        end
        n_cmp++;
        if (cnt != n) begin
            n_fail++;
            $display("FAIL %s plot_count: got %0d want %0d", nm, cnt, n);
        end
        n_cmp++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s pixel_stream: got %0d bad pixels want 0", nm, errs);
        end
        n_cmp++;
        if (first_rel != 2) begin
            n_fail++;
            $display("FAIL %s first_plot_latency: got %0d want 2", nm, first_rel);
        end
        n_cmp++;
        if (done_rel != n + 2) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d want %0d", nm, done_rel, n + 2);
        end
        n_cmp++;
        if (bus.vga_x !== XW'(xh) || bus.vga_y !== YW'(yh) || bus.busy !== 1'b0 ||
            bus.vga_plot !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_state: got x=%0d y=%0d busy=%0b plot=%0b want x=%0d y=%0d busy=0 plot=0",
                     nm, bus.vga_x, bus.vga_y, bus.busy, bus.vga_plot, xh, yh);
        end
    endtask

    task automatic release_start(input string nm);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.vga_plot !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: got done=%0b busy=%0b plot=%0b want 0/0/0",
                     nm, bus.done, bus.busy, bus.vga_plot);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.vga_x !== '0 || bus.vga_y !== '0 || bus.vga_colour !== '0 ||
            bus.vga_plot !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got x=%0d y=%0d c=%0d plot=%0b done=%0b busy=%0b want all 0",
                     bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.done, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_screen();
        do_fill("full_screen", 0, 159, 0, 119, 0, 5);
        release_start("full_screen");
    endtask

    task automatic test_swapped_corners();
        do_fill("swapped", 10, 7, 4, 2, 1, 0);
        release_start("swapped");
    endtask

    task automatic test_single_pixel();
        do_fill("single", 3, 3, 3, 3, 3, 6);
        release_start("single");
    endtask

    task automatic test_handshake();
        do_fill("hs_first", 20, 23, 30, 32, 2, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.done !== 1'b1 || bus.vga_plot !== 1'b0) begin
                n_fail++;
                $display("FAIL hs_hold cycle %0d: got done=%0b plot=%0b want 1/0",
                         i, bus.done, bus.vga_plot);
            end
        end
        release_start("hs_first");
        do_fill("hs_restart", 40, 35, 60, 66, 3, 7);
        release_start("hs_restart");
    endtask

    task automatic test_reset_mid_fill();
        int bx, by, cnt, extra;
        bx = $urandom_range(0, 140);
        by = $urandom_range(0, 100);
        @(negedge clk);
        bus.x0 = XW'(bx);     bus.x1 = XW'(bx + 9);
        bus.y0 = YW'(by + 9); bus.y1 = YW'(by);
        bus.mode = SOLID;     bus.colour = 3'd7;
        bus.start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 50; i++) begin
            @(posedge clk);
            #1;
            if (bus.vga_plot === 1'b1) cnt++;
        end
        n_cmp++;
        if (cnt != 50) begin
            n_fail++;
            $display("FAIL rst_mid reach_pixel50: got %0d want 50", cnt);
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.vga_x !== '0 || bus.vga_y !== '0 || bus.vga_colour !== '0 ||
            bus.vga_plot !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid outputs: got x=%0d y=%0d c=%0d plot=%0b done=%0b busy=%0b want all 0",
                     bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.done, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.vga_plot !== 1'b0 || bus.busy !== 1'b0) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL rst_mid no_plots_after: got %0d active cycles want 0", extra);
        end
        do_fill("rst_fresh", bx + 9, bx, by, by + 9, 0, 4);
        release_start("rst_fresh");
    endtask

    task automatic test_random();
        int ax0, ax1, ay0, ay1, lo, hi;
        for (int t = 0; t < 8; t++) begin
            ax0 = $urandom_range(0, SW - 1);
            ay0 = $urandom_range(0, SH - 1);
            lo = (ax0 > 12) ? ax0 - 12 : 0;
            hi = (ax0 + 12 < SW) ? ax0 + 12 : SW - 1;
            ax1 = $urandom_range(lo, hi);
            lo = (ay0 > 12) ? ay0 - 12 : 0;
            hi = (ay0 + 12 < SH) ? ay0 + 12 : SH - 1;
            ay1 = $urandom_range(lo, hi);
            do_fill($sformatf("random%0d", t), ax0, ax1, ay0, ay1,
                    $urandom_range(0, 3), $urandom_range(0, 7));
            release_start($sformatf("random%0d", t));
        end
    endtask

    task automatic test_clip();
        // Model clamps under RECT_FILL_CLIP_EN (100 plots), else 51x18.
        do_fill("clip", 150, 200, 110, 127, 0, 2);
        release_start("clip");
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.x0     = '0;
        bus.x1     = '0;
        bus.y0     = '0;
        bus.y1     = '0;
        bus.mode   = SOLID;
        bus.colour = '0;
        test_reset();
        test_single_pixel();
        test_swapped_corners();
        test_handshake();
        test_reset_mid_fill();
        test_random();
        test_clip();
        test_full_screen();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
